// File: rtl/demux_1n8_write_pkg.sv
// Shared types and constants for the 1-to-8 write demultiplexer.
// Holds the delivery FSM states and the channel geometry.
package demux_1n8_write_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        DELIVER = 1'b1
    } state_t;

endpackage

// File: rtl/demux_1n8_write_decoder_3n8.sv
// Combinational 3-to-8 one-hot decoder used to address the demux channels.
module decoder_3n8
    import demux_1n8_write_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] onehot
);

    // One-hot decode of the channel select
    always_comb begin
        onehot = 8'b0000_0000;
        case (sel)
            3'd0:    onehot = 8'b0000_0001;
            3'd1:    onehot = 8'b0000_0010;
            3'd2:    onehot = 8'b0000_0100;
            3'd3:    onehot = 8'b0000_1000;
            3'd4:    onehot = 8'b0001_0000;
            3'd5:    onehot = 8'b0010_0000;
            3'd6:    onehot = 8'b0100_0000;
            3'd7:    onehot = 8'b1000_0000;
            default: onehot = 8'b0000_0000;
        endcase
    end

endmodule

// File: rtl/demux_1n8_write.sv
// 1-to-8 write demultiplexer: routes one accepted word to a channel register,
// raises a one-hot strobe until acknowledged, and keeps a sticky written mask.
module demux_1n8_write
    import demux_1n8_write_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Hyrja,
    input  logic [SEL_W-1:0]  S,
    input  logic              Valid,
    output logic              Ready,
    input  logic              Ack,
    input  logic              Clear,
    output logic [WIDTH-1:0]  Dalja0,
    output logic [WIDTH-1:0]  Dalja1,
    output logic [WIDTH-1:0]  Dalja2,
    output logic [WIDTH-1:0]  Dalja3,
    output logic [WIDTH-1:0]  Dalja4,
    output logic [WIDTH-1:0]  Dalja5,
    output logic [WIDTH-1:0]  Dalja6,
    output logic [WIDTH-1:0]  Dalja7,
    output logic [NUM_CH-1:0] Strobe,
    output logic [NUM_CH-1:0] Written,
    output logic              Busy
);

    state_t                  state_r;
    logic [NUM_CH-1:0]       strobe_r;
    logic [NUM_CH-1:0]       written_r;
    logic [WIDTH-1:0]        dalja_r [NUM_CH];
    logic [NUM_CH-1:0]       sel_onehot_s;
    logic                    accept_s;

    decoder_3n8 u_decoder (
        .sel    (S),
        .onehot (sel_onehot_s)
    );

    assign accept_s = (state_r == IDLE) && Valid;

    // Delivery FSM, channel data registers and strobe
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r  <= IDLE;
            strobe_r <= 8'b0000_0000;
            for (int i = 0; i < NUM_CH; i++) begin
                dalja_r[i] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (Valid) begin
                        dalja_r[S] <= Hyrja;
                        strobe_r   <= sel_onehot_s;
                        state_r    <= DELIVER;
                    end
                end
                DELIVER: begin
                    // Inputs are ignored here; only Ack releases the strobe
                    if (Ack) begin
                        strobe_r <= 8'b0000_0000;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    strobe_r <= 8'b0000_0000;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // Sticky written mask; a simultaneous acceptance survives Clear
    always_ff @(posedge Clock) begin
        if (Reset) begin
            written_r <= 8'b0000_0000;
        end else begin
            written_r <= (Clear ? 8'b0000_0000 : written_r)
                       | (accept_s ? sel_onehot_s : 8'b0000_0000);
        end
    end

    assign Ready   = (state_r == IDLE);
    assign Busy    = (state_r != IDLE);
    assign Strobe  = strobe_r;
    assign Written = written_r;
    assign Dalja0  = dalja_r[0];
    assign Dalja1  = dalja_r[1];
    assign Dalja2  = dalja_r[2];
    assign Dalja3  = dalja_r[3];
    assign Dalja4  = dalja_r[4];
    assign Dalja5  = dalja_r[5];
    assign Dalja6  = dalja_r[6];
    assign Dalja7  = dalja_r[7];

endmodule

// File: tb/tb_demux_1n8_write.sv
// Directed self-checking bench for demux_1n8_write.
module tb_demux_1n8_write;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] Hyrja = 16'h0000;
    logic [2:0]  S     = 3'd0;
    logic        Valid = 1'b0;
    logic        Ack   = 1'b0;
    logic        Clear = 1'b0;
    logic        Ready;
    logic        Busy;
    logic [7:0]  Strobe;
    logic [7:0]  Written;
    logic [15:0] Dalja0, Dalja1, Dalja2, Dalja3, Dalja4, Dalja5, Dalja6, Dalja7;
    logic [15:0] dalja [8];

    int checks = 0;
    int passed = 0;

    demux_1n8_write #(.WIDTH(16)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Hyrja   (Hyrja),
        .S       (S),
        .Valid   (Valid),
        .Ready   (Ready),
        .Ack     (Ack),
        .Clear   (Clear),
        .Dalja0  (Dalja0),
        .Dalja1  (Dalja1),
        .Dalja2  (Dalja2),
        .Dalja3  (Dalja3),
        .Dalja4  (Dalja4),
        .Dalja5  (Dalja5),
        .Dalja6  (Dalja6),
        .Dalja7  (Dalja7),
        .Strobe  (Strobe),
        .Written (Written),
        .Busy    (Busy)
    );

    assign dalja[0] = Dalja0;
    assign dalja[1] = Dalja1;
    assign dalja[2] = Dalja2;
    assign dalja[3] = Dalja3;
    assign dalja[4] = Dalja4;
    assign dalja[5] = Dalja5;
    assign dalja[6] = Dalja6;
    assign dalja[7] = Dalja7;

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle before sampling/driving
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_all_dalja(input string tag, input logic [15:0] exp [8]);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_dalja%0d", tag, i), 32'(dalja[i]), 32'(exp[i]));
        end
    endtask

    task automatic write_ack(input logic [2:0] sel, input logic [15:0] data);
        Valid = 1'b1; S = sel; Hyrja = data;
        step();
        Valid = 1'b0; Ack = 1'b1;
        step();
        Ack = 1'b0;
    endtask

    logic [15:0] exp_d [8];

    initial begin
        // Reset state
        Reset = 1'b1;
        step(); step();
        Reset = 1'b0;
        chk("rst_ready",   32'(Ready),   32'd1);
        chk("rst_busy",    32'(Busy),    32'd0);
        chk("rst_strobe",  32'(Strobe),  32'h00);
        chk("rst_written", 32'(Written), 32'h00);
        for (int i = 0; i < 8; i++) exp_d[i] = 16'h0000;
        check_all_dalja("rst", exp_d);

        // Single write to channel 5
        Valid = 1'b1; S = 3'b101; Hyrja = 16'hBEEF;
        step();
        Valid = 1'b0;
        exp_d[5] = 16'hBEEF;
        check_all_dalja("w5", exp_d);
        chk("w5_strobe",  32'(Strobe),  32'h20);
        chk("w5_ready",   32'(Ready),   32'd0);
        chk("w5_busy",    32'(Busy),    32'd1);
        chk("w5_written", 32'(Written), 32'h20);

        // Stall in DELIVER while inputs wander
        for (int i = 0; i < 5; i++) begin
            Valid = 1'b1; S = 3'(i); Hyrja = 16'(16'h1111 * (i + 1));
            step();
            chk($sformatf("hold%0d_strobe", i), 32'(Strobe), 32'h20);
            chk($sformatf("hold%0d_dalja5", i), 32'(Dalja5), 32'hBEEF);
            chk($sformatf("hold%0d_dalja0", i), 32'(Dalja0), 32'h0000);
        end
        Valid = 1'b0; Ack = 1'b1;
        step();
        Ack = 1'b0;
        chk("ack_strobe", 32'(Strobe), 32'h00);
        chk("ack_ready",  32'(Ready),  32'd1);

        // Ack in IDLE has no effect
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        chk("idle_ack_ready",  32'(Ready),  32'd1);
        chk("idle_ack_strobe", 32'(Strobe), 32'h00);

        // Overwrite on channel 0 after a fresh reset
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rst2_dalja5", 32'(Dalja5), 32'h0000);
        write_ack(3'd0, 16'h1111);
        write_ack(3'd0, 16'h2222);
        chk("ovw_dalja0",  32'(Dalja0),  32'h2222);
        chk("ovw_written", 32'(Written), 32'h01);

        // Clear concurrent with acceptance
        write_ack(3'd7, 16'h7777);
        chk("pre_clr_written", 32'(Written), 32'h81);
        Clear = 1'b1; Valid = 1'b1; S = 3'b011; Hyrja = 16'h3333;
        step();
        Clear = 1'b0; Valid = 1'b0;
        chk("clr_acc_written", 32'(Written), 32'h08);
        chk("clr_acc_strobe",  32'(Strobe),  32'h08);
        Ack = 1'b1;
        step();
        Ack = 1'b0;

        // Clear alone zeroes the mask but keeps data
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        chk("clr_written", 32'(Written), 32'h00);
        chk("clr_dalja3",  32'(Dalja3),  32'h3333);
        chk("clr_dalja7",  32'(Dalja7),  32'h7777);

        // Reset aborts a pending strobe and wins over Valid
        Valid = 1'b1; S = 3'd6; Hyrja = 16'h6666;
        step();
        chk("pre_rst_strobe", 32'(Strobe), 32'h40);
        Reset = 1'b1;
        step();
        Reset = 1'b0; Valid = 1'b0;
        chk("abort_strobe",  32'(Strobe),  32'h00);
        chk("abort_ready",   32'(Ready),   32'd1);
        chk("abort_written", 32'(Written), 32'h00);
        for (int i = 0; i < 8; i++) exp_d[i] = 16'h0000;
        check_all_dalja("abort", exp_d);

        // Sweep all channels
        for (int k = 0; k < 8; k++) begin
            Valid = 1'b1; S = 3'(k); Hyrja = 16'(16'h0100 * k + k);
            step();
            Valid = 1'b0; Ack = 1'b1;
            chk($sformatf("sweep%0d_strobe", k), 32'(Strobe), 32'(8'h01 << k));
            step();
            Ack = 1'b0;
            chk($sformatf("sweep%0d_idle", k), 32'(Strobe), 32'h00);
            exp_d[k] = 16'(16'h0100 * k + k);
        end
        check_all_dalja("sweep", exp_d);
        chk("sweep_written", 32'(Written), 32'hFF);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
